// File: rtl/apb3_cmd_pkg.sv
// Shared types for the APB3 command requester: command/response records and FSM states.
package apb3_cmd_pkg;

  localparam int MAX_ADDR_W             = 32;
  localparam int MAX_DATA_W             = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 256;

  // Fields are sized for the widest configuration and cast at the ports.
  typedef struct packed {
    logic                  write;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } rsp_t;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_SETUP,
    STATE_ACCESS
  } state_t;

endpackage

// File: rtl/apb3_cmd_fifo.sv
// Synchronous command FIFO; Depth must be a power of 2 so pointers wrap naturally.
module apb3_cmd_fifo
  import apb3_cmd_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  cmd_t i_data,
  input  logic i_pop,
  output cmd_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  cmd_t            r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb3_cmd_requester.sv
// APB3 manager: queues read/write commands and runs them one at a time as SETUP/ACCESS transfers.
// Optional ACCESS wait timeout enabled by defining APB3_CMD_REQUESTER_TIMEOUT_EN.
module apb3_cmd_requester
  import apb3_cmd_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int CmdDepth      = 4,
  parameter int TimeoutCycles = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  logic [DataWidth-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [AddressWidth-1:0] paddr,
  output logic [DataWidth-1:0]    pwdata,
  input  logic                    pready,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pslverr
);

  cmd_t                    w_cmd_in;
  cmd_t                    w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_load;
  logic                    w_timeout_hit;
  state_t                  r_state;
  state_t                  w_state_nxt;
  rsp_t                    r_rsp;
  rsp_t                    w_rsp_nxt;
  logic                    r_rsp_valid;
  logic                    r_pwrite;
  logic [AddressWidth-1:0] r_paddr;
  logic [DataWidth-1:0]    r_pwdata;
  logic                    w_unused;

  always_comb begin
    w_cmd_in       = '0;
    w_cmd_in.write = cmd_write;
    w_cmd_in.addr  = MAX_ADDR_W'(cmd_addr);
    w_cmd_in.wdata = MAX_DATA_W'(cmd_wdata);
  end

  apb3_cmd_fifo #(.Depth(CmdDepth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready = !w_full;

`ifdef APB3_CMD_REQUESTER_TIMEOUT_EN
  localparam int WaitW = $clog2(TimeoutCycles + 1);
  logic [WaitW-1:0] r_wait;

  // Held at zero outside ACCESS, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (rst || r_state != STATE_ACCESS) r_wait <= '0;
    else if (!pready)                   r_wait <= r_wait + 1'b1;
  end

  assign w_timeout_hit = (r_state == STATE_ACCESS) && !pready &&
                         (r_wait == WaitW'(TimeoutCycles - 1));
  assign rsp_timeout   = r_rsp.timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign rsp_timeout   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_nxt   = r_rsp;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        // Only start when the response slot is free or being freed this cycle.
        if (!w_empty && (!r_rsp_valid || rsp_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = STATE_SETUP;
        end
      end
      STATE_SETUP: begin
        psel        = 1'b1;
        w_state_nxt = STATE_ACCESS;
      end
      STATE_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          w_load            = 1'b1;
          w_rsp_nxt.rdata   = r_pwrite ? '0 : MAX_DATA_W'(prdata);
          w_rsp_nxt.slverr  = pslverr;
          w_rsp_nxt.timeout = 1'b0;
          w_state_nxt       = STATE_IDLE;
        end else if (w_timeout_hit) begin
          w_load            = 1'b1;
          w_rsp_nxt.rdata   = '0;
          w_rsp_nxt.slverr  = 1'b1;
          w_rsp_nxt.timeout = 1'b1;
          w_state_nxt       = STATE_IDLE;
        end
      end
      default: w_state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= STATE_IDLE;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A new load takes priority over a same-cycle consume.
      if (w_load) begin
        r_rsp       <= w_rsp_nxt;
        r_rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_pop) begin
        r_pwrite <= w_head.write;
        r_paddr  <= w_head.addr[AddressWidth-1:0];
        r_pwdata <= w_head.wdata[DataWidth-1:0];
      end
    end
  end

  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp.rdata[DataWidth-1:0];
  assign rsp_slverr = r_rsp.slverr;

  assign w_unused = ^{w_head.addr, w_head.wdata, r_rsp, TimeoutCycles[0]};

endmodule

// File: tb/tb_apb3_cmd_requester.sv
// Directed bench for apb3_cmd_requester; inputs driven and outputs sampled on the falling edge,
// so a value seen at a negedge is the level the next rising edge samples.
module tb_apb3_cmd_requester;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int            tb_wait = 0;
  bit            tb_hang = 1'b0;
  bit            tb_use_fixed = 1'b0;
  logic [DW-1:0] tb_prdata = '0;
  int            acc_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  apb3_cmd_requester #(
    .AddressWidth(AW), .DataWidth(DW), .CmdDepth(4), .TimeoutCycles(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Completer model: inserts tb_wait wait states per ACCESS, or never answers while tb_hang.
  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end
  assign pready = !tb_hang && (acc_cnt >= tb_wait);
  assign prdata = tb_use_fixed ? tb_prdata : {12'hC0D, paddr};

  task automatic present(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic rdy);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    rdy = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; pslverr = 0; rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rsp_valid=%b rdata=%h slverr=%b timeout=%b, expected all 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b psel=%b rsp_valid=%b, expected 1 0 0", cmd_ready, psel, rsp_valid);
    end
  endtask

  task automatic test_write_latency();
    logic rdy;
    rsp_ready = 0; tb_wait = 0;
    present(1'b1, 20'h00040, 32'h0000_1234, rdy);   // edge N has passed
    n_checks++;
    if (rdy !== 1'b1 || psel !== 1'b0) begin
      n_fail++; $display("FAIL write_n1: ready=%b psel=%b, expected 1 0", rdy, psel);
    end
    @(negedge clk);
    n_checks++;
    if (psel !== 1'b1 || penable !== 1'b0) begin
      n_fail++; $display("FAIL write_n2_setup: psel=%b penable=%b, expected 1 0", psel, penable);
    end
    @(negedge clk);
    n_checks++;
    if (penable !== 1'b1 || paddr !== 20'h00040 || pwdata !== 32'h1234 || pwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL write_n3_access: penable=%b paddr=%h pwdata=%h pwrite=%b, expected 1 00040 00001234 1",
               penable, paddr, pwdata, pwrite);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== '0 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0 || psel !== 1'b0) begin
      n_fail++;
      $display("FAIL write_n4_rsp: valid=%b rdata=%h slverr=%b timeout=%b psel=%b, expected 1 0 0 0 0",
               rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, psel);
    end
    consume();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_rsp_clear: rsp_valid=%b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_wait_read();
    logic rdy; bit ok; bit addr_ok; int pen;
    tb_wait = 3; tb_use_fixed = 1; tb_prdata = 32'hDEAD_BEEF; rsp_ready = 0;
    present(1'b0, 20'h00100, 32'hFFFF_FFFF, rdy);
    ok = 0; addr_ok = 1; pen = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rsp_valid) ok = 1;
      else begin
        if (penable) begin
          pen++;
          if (paddr !== 20'h00100 || pwrite !== 1'b0) addr_ok = 0;
        end
        @(negedge clk);
      end
    end
    n_checks++;
    if (!ok || pen != 4 || !addr_ok) begin
      n_fail++; $display("FAIL wait_penable: rsp_seen=%0d penable_cycles=%0d addr_ok=%0d, expected 1 4 1", ok, pen, addr_ok);
    end
    n_checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF || rsp_slverr !== 1'b0) begin
      n_fail++; $display("FAIL wait_rdata: rdata=%h slverr=%b, expected deadbeef 0", rsp_rdata, rsp_slverr);
    end
    consume();
    tb_wait = 0; tb_use_fixed = 0;
  endtask

  task automatic test_back_to_back();
    logic rdy; bit ready_ok; int got;
    logic [AW-1:0] a [5];
    logic [DW-1:0] exp_d [5];
    for (int i = 0; i < 5; i++) begin
      a[i] = AW'(32'h10 + 4 * i);
      exp_d[i] = (i == 2) ? 32'h0 : {12'hC0D, a[i]};
    end
    rsp_ready = 0; ready_ok = 1;
    for (int i = 0; i < 5; i++) begin
      present(i == 2, a[i], 32'h5555_5555, rdy);
      if (rdy !== 1'b1) ready_ok = 0;
    end
    n_checks++;
    if (!ready_ok) begin
      n_fail++; $display("FAIL b2b_accept: not all 5 commands saw cmd_ready=1, expected all accepted");
    end
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: cmd_ready=%b, expected 0", cmd_ready);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d[0] || cmd_ready !== 1'b0 || psel !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall: rsp_valid=%b rdata=%h cmd_ready=%b psel=%b, expected 1 %h 0 0",
               rsp_valid, rsp_rdata, cmd_ready, psel, exp_d[0]);
    end
    rsp_ready = 1; got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (rsp_valid) begin
        n_checks++;
        if (rsp_rdata !== exp_d[got] || rsp_slverr !== 1'b0) begin
          n_fail++; $display("FAIL b2b_order[%0d]: rdata=%h slverr=%b, expected %h 0", got, rsp_rdata, rsp_slverr, exp_d[got]);
        end
        got++;
      end
      @(negedge clk);
    end
    rsp_ready = 0;
    n_checks++;
    if (got != 5) begin
      n_fail++; $display("FAIL b2b_count: responses=%0d, expected 5", got);
    end
  endtask

  task automatic test_slverr();
    logic rdy; bit ok;
    tb_use_fixed = 1; tb_prdata = 32'h0BAD_F00D; pslverr = 1; rsp_ready = 0;
    present(1'b0, 20'h00008, 32'h0, rdy);
    wait_rsp(20, ok);
    n_checks++;
    if (!ok || rsp_slverr !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL slverr_rsp: seen=%0d slverr=%b timeout=%b rdata=%h, expected 1 1 0 0badf00d",
               ok, rsp_slverr, rsp_timeout, rsp_rdata);
    end
    consume();
    pslverr = 0; tb_use_fixed = 0;
  endtask

`ifdef APB3_CMD_REQUESTER_TIMEOUT_EN
  task automatic test_timeout();
    logic rdy; bit ok; int pen;
    tb_hang = 1; rsp_ready = 0;
    present(1'b0, 20'h00020, 32'h0, rdy);
    present(1'b1, 20'h00024, 32'hA0A0_A0A0, rdy);
    ok = 0; pen = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rsp_valid) ok = 1;
      else begin
        if (penable) pen++;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!ok || pen != 8 || rsp_timeout !== 1'b1 || rsp_slverr !== 1'b1 || rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL timeout_abort: seen=%0d access_cycles=%0d timeout=%b slverr=%b rdata=%h, expected 1 8 1 1 0",
               ok, pen, rsp_timeout, rsp_slverr, rsp_rdata);
    end
    tb_hang = 0;
    consume();
    wait_rsp(20, ok);
    n_checks++;
    if (!ok || rsp_timeout !== 1'b0 || rsp_slverr !== 1'b0 || rsp_rdata !== '0 || paddr !== 20'h00024) begin
      n_fail++;
      $display("FAIL timeout_next: seen=%0d timeout=%b slverr=%b rdata=%h paddr=%h, expected 1 0 0 0 00024",
               ok, rsp_timeout, rsp_slverr, rsp_rdata, paddr);
    end
    consume();
  endtask
`endif

  task automatic test_reset_mid();
    logic rdy; bit ok; bit quiet;
    tb_hang = 1; rsp_ready = 0;
    for (int i = 0; i < 3; i++) present(1'b0, AW'(32'h30 + 4 * i), 32'h0, rdy);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (penable) ok = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rstmid_access: penable never rose, expected ACCESS within 10 cycles");
    end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_bus: psel=%b penable=%b rsp_valid=%b, expected 0 0 0", psel, penable, rsp_valid);
    end
    rst = 0; tb_hang = 0; quiet = 1;
    repeat (12) begin
      @(negedge clk);
      if (psel || rsp_valid) quiet = 0;
    end
    n_checks++;
    if (!quiet || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_drop: quiet=%0d cmd_ready=%b, expected 1 1", quiet, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_wait_read();
    test_back_to_back();
    test_slverr();
`ifdef APB3_CMD_REQUESTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb3_cmd_requester.md
Name: apb3_cmd_requester

Overview:
- Synthesizable APB3 manager that sits directly upstream of an APB3 completer and drives its pclk-domain bus (psel/penable/paddr/pwrite/pwdata in, pready/prdata/pslverr back).
- Accepts read/write commands on a valid/ready stream, queues them in a small FIFO and executes them one at a time as SETUP/ACCESS transfers.
- Returns one response per command on a valid/ready stream.
- Used as the hardware-side stimulus source for co-simulated APB3 completers and as a standalone bus driver in the integration library.

Parameters:
- AddressWidth, 20, APB paddr width.
- DataWidth, 32, APB pwdata/prdata width; 8, 16 or 32 only.
- CmdDepth, 4, command FIFO entries; power of 2, at least 2.
- TimeoutCycles, 256, ACCESS cycles without pready before abort; at least 1; used only with the timeout feature.

Ports:
- clk  in  1  bus clock, equal to pclk.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AddressWidth  transfer address.
- cmd_wdata  in  DataWidth  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DataWidth  read data; 0 for writes.
- rsp_slverr  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AddressWidth  APB address.
- pwdata  out  DataWidth  APB write data.
- pready  in  1  completer ready.
- prdata  in  DataWidth  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst. Every register is reset only on a rising clk edge with rst=1.
- Reset values: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr and rsp_timeout are all 0. cmd_ready is 1 the cycle after reset releases. FIFO is empty; FSM is in IDLE.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full. Registered count, width $clog2(CmdDepth)+1.
  - When full, push is refused even if a pop happens in the same cycle.
  - A command pushed into an empty FIFO can be popped at the earliest on the next cycle.
  - Pointers wrap modulo CmdDepth.
- FSM states and transitions:
  - IDLE: psel=0, penable=0. If the FIFO is not empty and (!rsp_valid || rsp_ready), pop the head, latch pwrite/paddr/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0. Exactly one cycle, then go to ACCESS.
  - ACCESS: psel=1, penable=1. pready is sampled only in this state.
    - On pready=1: load rsp_rdata (prdata if read, 0 if write), rsp_slverr=pslverr, rsp_timeout=0; set rsp_valid; go to IDLE.
    - On pready=0: stay in ACCESS.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- Minimum cadence is 3 cycles per transfer (IDLE, SETUP, ACCESS); there is no back-to-back SETUP.
- Response register: rsp_valid clears on rsp_ready. rsp_* fields are stable while rsp_valid && !rsp_ready. A clear and a new load may occur in the same cycle; the load wins.
- Latency: with an empty FIFO and pready tied to 1, cmd accepted at edge N gives psel=1 at N+2 and rsp_valid=1 at N+4.
- Ordering: responses come back in command order. There is never more than one transfer in flight.
- Reset mid-transfer: the bus returns to idle on the next edge, queued commands are dropped and no response is produced for them.

Optional Feature:
- Macro: APB3_CMD_REQUESTER_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the count reaches TimeoutCycles with pready still 0, go to IDLE (psel/penable fall at that edge).
  - The response is rsp_timeout=1, rsp_slverr=1, rsp_rdata=0.
  - A pready=1 in the same cycle the count limit is reached completes the transfer normally.
- When not defined: ACCESS waits indefinitely, the counter is absent and rsp_timeout is tied to 0.

Decomposition:
- Shared package apb3_cmd_pkg:
  - cmd_t: write, addr, wdata, with maximum-width fields cast at the ports.
  - rsp_t: rdata, slverr, timeout.
  - state_t enum: STATE_IDLE, STATE_SETUP, STATE_ACCESS.
  - Default TimeoutCycles constant.
- One sub-module, apb3_cmd_fifo: a synchronous FIFO of cmd_t, parameterized by depth, with full/empty/push/pop.

Test Plan:
- After reset, write 0x0000_1234 to 0x00040 with pready=1: psel at N+2, penable at N+3 with paddr=0x00040 and pwdata=0x1234; rsp_valid at N+4 with rdata=0, slverr=0.
- Read 0x00100 with the completer inserting 3 wait states and prdata=0xDEADBEEF: penable stays high for 4 cycles; rsp_rdata=0xDEADBEEF.
- Push 5 commands with CmdDepth=4 and rsp_ready=0: cmd_ready falls after the 4th push plus one pop. Only one transfer completes until rsp_ready=1. All 5 responses arrive in order.
- Completer returns pslverr=1 on a read of 0x00008: rsp_slverr=1, rsp_timeout=0, rsp_rdata equals sampled prdata.
- With the macro defined, TimeoutCycles=8 and pready held 0: abort after 8 ACCESS cycles; rsp_timeout=1, rsp_slverr=1, rsp_rdata=0; the next queued command proceeds.
- rst=1 asserted during ACCESS with 2 commands queued: psel=penable=0 on the next edge, FIFO empty, no rsp_valid.
